// File: rtl/frame_level_pkg.sv
// Shared types and constants for the frame level meter: sample/magnitude widths and FSM states.
package frame_level_pkg;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned FRAME_LEN = 256;

    typedef enum logic [1:0] {IDLE, READ, FINISH} state_e;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [DATA_W-2:0]        mag_t;

endpackage

// File: rtl/frame_level_meter_if.sv
// Sample RAM read port: valid/ready data handshake plus the "full frame available" flag.
interface frame_level_meter_if;
    import frame_level_pkg::*;

    sample_t read_data;
    logic    read_valid;
    logic    read_ready;
    logic    buffer_ready;

    modport master (output read_data, output read_valid, output buffer_ready, input read_ready);
    modport slave  (input read_data, input read_valid, input buffer_ready, output read_ready);

endinterface

// File: rtl/abs_sat.sv
// Signed sample to unsigned magnitude; the most negative code saturates to the largest magnitude.
module abs_sat
    import frame_level_pkg::*;
(
    input  sample_t sample_i,
    output mag_t    mag_o
);

    localparam sample_t MinVal = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        if (sample_i == MinVal) begin
            mag_o = '1;
        end else if (sample_i[DATA_W-1]) begin
            mag_o = mag_t'(-sample_i);
        end else begin
            mag_o = mag_t'(sample_i);
        end
    end

endmodule

// File: rtl/frame_level_meter.sv
// Drains one frame of samples from the RAM read port and reports its peak and mean magnitude.
module frame_level_meter
    import frame_level_pkg::*;
#(
    parameter int unsigned FRAME_LEN = frame_level_pkg::FRAME_LEN,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    frame_level_meter_if.slave  ram_if,
    output mag_t                peak_o,
    output mag_t                mean_abs_o,
    output logic                frame_valid_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    sample_count_o
);

    localparam int unsigned LOG2_LEN = $clog2(FRAME_LEN);
    localparam int unsigned ACC_W    = DATA_W - 1 + LOG2_LEN;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    mag_t               peak_q, peak_d;
    mag_t               peak_out_q, peak_out_d;
    mag_t               mean_q, mean_d;
    logic               fvalid_q, fvalid_d;
    mag_t               mag;
    logic               beat;

    abs_sat u_abs_sat (
        .sample_i (ram_if.read_data),
        .mag_o    (mag)
    );

    assign beat = (state_q == READ) && ram_if.read_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        peak_out_d = peak_out_q;
        mean_d     = mean_q;
        fvalid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_if.buffer_ready) begin
                    state_d = READ;
                    cnt_d   = '0;
                    acc_d   = '0;
                    peak_d  = '0;
                end
            end
            READ: begin
                // buffer_ready is deliberately ignored here: a started frame always completes.
                if (beat) begin
                    acc_d = acc_q + ACC_W'(mag);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (mag > peak_q) begin
                        peak_d = mag;
                    end
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                peak_out_d = peak_q;
                mean_d     = acc_q[ACC_W-1:LOG2_LEN];
                fvalid_d   = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            peak_out_q <= '0;
            mean_q     <= '0;
            fvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            peak_out_q <= peak_out_d;
            mean_q     <= mean_d;
            fvalid_q   <= fvalid_d;
        end
    end

    assign ram_if.read_ready = (state_q == READ);
    assign busy_o            = (state_q != IDLE);
    assign sample_count_o    = cnt_q;
    assign peak_o            = peak_out_q;
    assign mean_abs_o        = mean_q;
    assign frame_valid_o     = fvalid_q;

endmodule

// File: tb/tb_frame_level_meter.sv
// Scoreboard bench for frame_level_meter with FRAME_LEN=4 and hand-computed frame results.
module tb_frame_level_meter;
    import frame_level_pkg::*;

    localparam int unsigned FLEN = 4;
    localparam int unsigned CW   = $clog2(FLEN) + 1;

    typedef struct {
        int peak;
        int mean;
    } exp_t;
    typedef int frame_t[4];

    logic          clk = 1'b0;
    logic          rst;
    mag_t          peak;
    mag_t          mean_abs;
    logic          frame_valid;
    logic          busy;
    logic [CW-1:0] sample_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   cyc = 0;
    int   last_beat = 0;
    int   beats = 0;

    frame_level_meter_if ram_if ();

    frame_level_meter #(.FRAME_LEN(FLEN)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ram_if         (ram_if),
        .peak_o         (peak),
        .mean_abs_o     (mean_abs),
        .frame_valid_o  (frame_valid),
        .busy_o         (busy),
        .sample_count_o (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat bookkeeping at the active edge, before the DUT state updates.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            beats <= 0;
        end else if (ram_if.read_valid && ram_if.read_ready) begin
            beats     <= beats + 1;
            last_beat <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected frame_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("peak_o", peak, e.peak);
                check("mean_abs_o", mean_abs, e.mean);
                // Registered on the edge after the one that accepted the last beat.
                check("frame_valid latency", cyc - last_beat, 1);
                check("beats per frame", beats, FLEN);
                beats = 0;
            end
        end
    end

    task automatic send(input int v, input int gap, output int waits);
        bit accepted;
        if (gap > 0) begin
            ram_if.read_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        ram_if.read_data  = sample_t'(v);
        ram_if.read_valid = 1'b1;
        waits    = 0;
        accepted = 1'b0;
        while (!accepted && waits <= 50) begin
            @(posedge clk);
            if (ram_if.read_ready) accepted = 1'b1;
            else waits++;
        end
        if (!accepted) check("beat accept timeout", 0, 1);
        #1;
    endtask

    task automatic run_frame(input frame_t s, input int pk, input int mn, input int gap,
                             input int drop_at);
        int w;
        exp_q.push_back('{peak: pk, mean: mn});
        ram_if.buffer_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(s[i], gap, w);
            if (i == drop_at) ram_if.buffer_ready = 1'b0;
        end
        ram_if.read_valid = 1'b0;
        check("ready in FINISH", ram_if.read_ready, 0);
        check("busy in FINISH", busy, 1);
        check("count in FINISH", sample_count, FLEN);
        @(posedge clk);
        #1;
        check("ready in IDLE", ram_if.read_ready, 0);
        check("busy in IDLE", busy, 0);
        check("count in IDLE", sample_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        frame_t f;
        rst = 1'b1;
        ram_if.read_data    = '0;
        ram_if.read_valid   = 1'b0;
        ram_if.buffer_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset peak_o", peak, 0);
        check("reset mean_abs_o", mean_abs, 0);
        check("reset frame_valid_o", frame_valid, 0);
        check("reset busy_o", busy, 0);
        check("reset ready", ram_if.read_ready, 0);
        check("reset sample_count_o", sample_count, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame: sum 650 >> 2 = 162.
        f = '{100, -200, 300, -50};
        run_frame(f, 300, 162, 0, 2);
        repeat (3) @(posedge clk);
        #1;
        check("peak_o held", peak, 300);
        check("mean_abs_o held", mean_abs, 162);

        // Saturation of the most negative code.
        f = '{-8388608, 0, 0, 0};
        run_frame(f, 8388607, 2097151, 0, 1);
        repeat (2) @(posedge clk);
        #1;

        // Valid toggling every other cycle: same result as the gap-free run.
        f = '{100, -200, 300, -50};
        run_frame(f, 300, 162, 1, 3);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: 10000>>2 = 2500, then 29>>2 = 7.
        exp_q.push_back('{peak: 4000, mean: 2500});
        exp_q.push_back('{peak: 8, mean: 7});
        ram_if.buffer_ready = 1'b1;
        f = '{1000, -2000, 3000, -4000};
        for (int i = 0; i < 4; i++) send(f[i], 0, w);
        f = '{7, -7, 7, -8};
        send(f[0], 0, w);
        check("b2b non-ready gap", w, 2);
        ram_if.buffer_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            send(f[i], 0, w);
            check("b2b no stall in READ", w, 0);
        end
        ram_if.read_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b peak replaced", peak, 8);

        // Reset mid-frame after two beats.
        ram_if.buffer_ready = 1'b1;
        send(100, 0, w);
        send(200, 0, w);
        ram_if.read_valid   = 1'b0;
        ram_if.buffer_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid-frame reset peak_o", peak, 0);
        check("mid-frame reset mean_abs_o", mean_abs, 0);
        check("mid-frame reset busy_o", busy, 0);
        check("mid-frame reset count", sample_count, 0);
        check("mid-frame reset ready", ram_if.read_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        f = '{-1, -2, -3, -6};
        run_frame(f, 6, 3, 0, 3);
        repeat (2) @(posedge clk);
        #1;

        // buffer_ready dropped right after the first beat: 260>>2 = 65.
        f = '{50, -60, 70, -80};
        run_frame(f, 80, 65, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("no restart while buffer_ready low", busy, 0);
        end

        check("pending expected frames", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
